// File: rtl/shift_reg16_core.sv
// 16-bit command-driven shift register: load/shift/rotate/serial/clear over valid/ready,
// with the logical-left path masked by an external left-shift mask decoder.
module shift_reg16_core #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    output logic [AMT_W-1:0] lsh_amt,
    input  logic [WIDTH-1:0] lsh_mask,
    output logic [WIDTH-1:0] q,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SAR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_SERL = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state;
    logic [2:0]         op;
    logic [WIDTH-1:0]   data;
    logic [AMT_W-1:0]   cnt;
    logic [WIDTH-1:0]   exec_val;
    logic [2*WIDTH-1:0] rol_wide;
    logic [2*WIDTH-1:0] ror_wide;

    assign cmd_ready = (state == IDLE) && !rst;
    assign res_valid = (state == DONE);

    // lsh_amt doubles as the latched shift amount so the decoder mask and the
    // shifter always see the same value.
    always_comb begin
        rol_wide = {q, q} << lsh_amt;
        ror_wide = {q, q} >> lsh_amt;
        exec_val = q;
        case (op)
            OP_LOAD: exec_val = data;
            OP_SHL:  exec_val = (q & lsh_mask) << lsh_amt;
            OP_SHR:  exec_val = q >> lsh_amt;
            OP_SAR:  exec_val = $signed(q) >>> lsh_amt;
            OP_ROL:  exec_val = rol_wide[2*WIDTH-1:WIDTH];
            OP_ROR:  exec_val = ror_wide[WIDTH-1:0];
            OP_CLR:  exec_val = '0;
            default: exec_val = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            q       <= '0;
            lsh_amt <= '0;
            op      <= OP_LOAD;
            data    <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op      <= cmd_op;
                        data    <= cmd_data;
                        lsh_amt <= cmd_amt;
                        cnt     <= cmd_amt;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (op == OP_SERL) begin
                        // The last shift and the move to DONE share an edge, giving N cycles for N shifts.
                        if (cnt != '0) begin
                            q   <= {q[WIDTH-2:0], ser_in};
                            cnt <= cnt - 1'b1;
                            if (cnt == AMT_W'(1)) begin
                                state <= DONE;
                            end
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        q     <= exec_val;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg16_core.sv
// Directed and random checks of shift_reg16_core with a result scoreboard and
// a behavioural model of the left-shift mask decoder.
module tb_shift_reg16_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_amt;
    logic [15:0] cmd_data;
    logic        ser_in;
    logic [3:0]  lsh_amt;
    logic [15:0] lsh_mask;
    logic [15:0] q;
    logic        res_valid;
    logic        res_ready;

    logic [15:0] exp_q[$];
    logic [15:0] model_q;
    logic [3:0]  last_amt;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Decoder: low (16 - amt) bits set.
    assign lsh_mask = 16'hFFFF >> lsh_amt;

    shift_reg16_core #(.WIDTH(16), .AMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .ser_in    (ser_in),
        .lsh_amt   (lsh_amt),
        .lsh_mask  (lsh_mask),
        .q         (q),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model(input logic [2:0] op, input int amt,
                                          input logic [15:0] d, input logic [15:0] cur);
        logic [15:0] r;
        r = cur;
        if (op == 3'd0) r = d;
        else if (op == 3'd7) r = 16'h0000;
        else begin
            for (int i = 0; i < 16; i++) begin
                if (op == 3'd1)      r[i] = (i >= amt) ? cur[i - amt] : 1'b0;
                else if (op == 3'd2) r[i] = (i + amt <= 15) ? cur[i + amt] : 1'b0;
                else if (op == 3'd3) r[i] = (i + amt <= 15) ? cur[i + amt] : cur[15];
                else if (op == 3'd4) r[i] = cur[(i - amt + 16) % 16];
                else if (op == 3'd5) r[i] = cur[(i + amt) % 16];
            end
        end
        return r;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [3:0] amt,
                         input logic [15:0] data, input logic [15:0] exp);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("cmd_ready_wait", {15'b0, cmd_ready}, 16'h0001);
        cmd_op = op;
        cmd_amt = amt;
        cmd_data = data;
        cmd_valid = 1'b1;
        exp_q.push_back(exp);
        model_q = exp;
        last_amt = amt;
        step();
        cmd_valid = 1'b0;
        check("lsh_amt_accept", {12'b0, lsh_amt}, {12'b0, amt});
    endtask

    task automatic collect(input string tag, input int exp_lat, input logic [15:0] pat, input int hold);
        int n = 0;
        logic [15:0] exp;
        while (!res_valid && n < 40) begin
            ser_in = pat[n[3:0]];
            step();
            n++;
        end
        check({tag, "_latency"}, n[15:0], exp_lat[15:0]);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_q"}, q, exp);
            check({tag, "_hold_valid"}, {15'b0, res_valid}, 16'h0001);
            check({tag, "_hold_ready"}, {15'b0, cmd_ready}, 16'h0000);
            step();
        end
        check(tag, q, exp);
        check({tag, "_lsh_amt"}, {12'b0, lsh_amt}, {12'b0, last_amt});
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, {15'b0, res_valid}, 16'h0000);
        check({tag, "_ready_back"}, {15'b0, cmd_ready}, 16'h0001);
        $display("txn %s: q=%h expected=%h latency=%0d", tag, q, exp, n);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [3:0]  r_amt;
        logic [15:0] r_data;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_amt = 4'd0;
        cmd_data = 16'h0000;
        ser_in = 1'b0;
        res_ready = 1'b0;
        model_q = 16'h0000;
        last_amt = 4'd0;
        step();
        step();
        check("rst_cmd_ready", {15'b0, cmd_ready}, 16'h0000);
        check("rst_q", q, 16'h0000);
        check("rst_res_valid", {15'b0, res_valid}, 16'h0000);
        check("rst_lsh_amt", {12'b0, lsh_amt}, 16'h0000);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {15'b0, cmd_ready}, 16'h0001);

        issue(3'd0, 4'd0, 16'hA5C3, 16'hA5C3);
        collect("load_a5c3", 1, 16'h0, 0);

        issue(3'd0, 4'd0, 16'h8001, 16'h8001); collect("load_8001", 1, 16'h0, 0);
        issue(3'd1, 4'd1, 16'h0000, 16'h0002); collect("shl1", 1, 16'h0, 0);
        issue(3'd0, 4'd0, 16'h8001, 16'h8001); collect("load_8001", 1, 16'h0, 0);
        issue(3'd2, 4'd15, 16'h0000, 16'h0001); collect("shr15", 1, 16'h0, 0);
        issue(3'd0, 4'd0, 16'h8001, 16'h8001); collect("load_8001", 1, 16'h0, 0);
        issue(3'd3, 4'd4, 16'h0000, 16'hF800); collect("sar4", 1, 16'h0, 0);
        issue(3'd0, 4'd0, 16'h8001, 16'h8001); collect("load_8001", 1, 16'h0, 0);
        issue(3'd4, 4'd1, 16'h0000, 16'h0003); collect("rol1", 1, 16'h0, 0);
        issue(3'd0, 4'd0, 16'h8001, 16'h8001); collect("load_8001", 1, 16'h0, 0);
        issue(3'd5, 4'd1, 16'h0000, 16'hC000); collect("ror1", 1, 16'h0, 0);

        issue(3'd0, 4'd0, 16'h8001, 16'h8001); collect("load_8001", 1, 16'h0, 0);
        for (int op = 1; op <= 5; op++) begin
            issue(op[2:0], 4'd0, 16'h0000, 16'h8001);
            collect("amt0", 1, 16'h0, 0);
        end
        issue(3'd6, 4'd0, 16'h0000, 16'h8001); collect("serl_amt0", 1, 16'h0, 0);

        issue(3'd7, 4'd0, 16'h0000, 16'h0000); collect("clr", 1, 16'h0, 0);
        issue(3'd6, 4'd3, 16'h0000, 16'h0005); collect("serl3", 3, 16'b101, 0);

        // Backpressure with a competing command held on the input
        issue(3'd0, 4'd0, 16'h0F0F, 16'h0F0F); collect("load_0f0f", 1, 16'h0, 0);
        issue(3'd1, 4'd2, 16'h0000, 16'h3C3C);
        cmd_op = 3'd0;
        cmd_amt = 4'd0;
        cmd_data = 16'h1234;
        cmd_valid = 1'b1;
        collect("bp_shl2", 1, 16'h0, 5);
        exp_q.push_back(16'h1234);
        model_q = 16'h1234;
        last_amt = 4'd0;
        step();
        cmd_valid = 1'b0;
        collect("bp_next_load", 1, 16'h0, 0);

        // Asynchronous reset in the middle of a long serial shift
        issue(3'd6, 4'd15, 16'h0000, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            ser_in = 1'b1;
            step();
        end
        check("serl_partial_nonzero", {15'b0, q != 16'h0000}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q", q, 16'h0000);
        check("async_rst_valid", {15'b0, res_valid}, 16'h0000);
        check("async_rst_ready", {15'b0, cmd_ready}, 16'h0000);
        exp_q.delete();
        step();
        rst = 1'b0;
        #1;
        check("rst_release_idle", {15'b0, cmd_ready}, 16'h0001);
        model_q = 16'h0000;
        issue(3'd0, 4'd0, 16'h1234, 16'h1234); collect("after_rst_load", 1, 16'h0, 0);

        issue(3'd0, 4'd0, 16'hFFFF, 16'hFFFF); collect("load_ffff", 1, 16'h0, 0);
        issue(3'd7, 4'd0, 16'h0000, 16'h0000); collect("clr_ffff", 1, 16'h0, 0);
        issue(3'd0, 4'd0, 16'h00FF, 16'h00FF); collect("load_00ff", 1, 16'h0, 0);
        issue(3'd1, 4'd8, 16'h0000, 16'hFF00); collect("shl8", 1, 16'h0, 0);

        for (int i = 0; i < 12; i++) begin
            r_op = 3'($urandom_range(0, 5));
            if (i % 4 == 3) r_op = 3'd7;
            r_amt = 4'($urandom_range(0, 15));
            r_data = 16'($urandom);
            issue(r_op, r_amt, r_data, model(r_op, int'(r_amt), r_data, model_q));
            collect("random", 1, 16'h0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
